inst_prefetch: RTL and testbench

Instruction prefetch buffer between the core's fetch port and instruction memory. It streams sequential words from memory into a DEPTH-entry FIFO ahead of the PC. It serves the core combinationally when the head entry matches the requested address. It flushes and refetches on any address mismatch (branch, jump or trap redirect).

---
 rtl/inst_prefetch.sv | 152 +++++++++++++++
 tb/tb_inst_prefetch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: streams sequential words into a FIFO ahead of the core PC.
// Optional hit/miss counters are enabled with `define IFETCH_PREFETCH_PERF_EN.
module inst_prefetch #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_inst_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
`ifdef IFETCH_PREFETCH_PERF_EN
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
`endif
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]      fifo_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [31:0]      head_addr_q, head_addr_d;
    logic [31:0]      req_addr_q, req_addr_d;

    logic             mismatch;
    logic             pop;
    logic             grant;
    logic             push;
    logic             drop;
    logic [SUM_W-1:0] in_flight;

    // Serve and request decisions; mem_req_o is held low while reset is asserted.
    always_comb begin
        mismatch      = (head_addr_q != fetch_addr_i);
        in_flight     = SUM_W'(count_q) + SUM_W'(outstanding_q);
        fetch_valid_o = (count_q != '0) && !mismatch;
        fetch_inst_o  = fetch_valid_o ? fifo_q[rd_ptr_q] : NOP;
        mem_req_o     = rst && !mismatch && (in_flight < SUM_W'(DEPTH));
        mem_addr_o    = req_addr_q;
        pop           = fetch_valid_o && fetch_ready_i;
        grant         = mem_req_o && mem_gnt_i;
        drop          = mem_rvalid_i && (discard_q != '0);
        push          = mem_rvalid_i && (discard_q == '0) && !mismatch;
    end

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        head_addr_d   = head_addr_q;
        req_addr_d    = req_addr_q;
        if (mismatch) begin
            // Redirect: everything still in flight becomes stale.
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            head_addr_d   = fetch_addr_i;
            req_addr_d    = fetch_addr_i;
            outstanding_d = outstanding_q - CNT_W'(mem_rvalid_i);
            discard_d     = outstanding_q - CNT_W'(mem_rvalid_i);
        end else begin
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                head_addr_d = head_addr_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (grant) begin
                req_addr_d = req_addr_q + 32'd4;
            end
            if (drop) begin
                discard_d = discard_q - CNT_W'(1);
            end
            count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
            outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(mem_rvalid_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            head_addr_q   <= RESET_ADDR;
            req_addr_q    <= RESET_ADDR;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            head_addr_q   <= head_addr_d;
            req_addr_q    <= req_addr_d;
        end
    end

    // Data storage needs no reset; count_q gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

`ifdef IFETCH_PREFETCH_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (pop && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (mismatch && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed self-checking bench for inst_prefetch with an in-order, variable-latency memory model.
module tb_inst_prefetch;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef IFETCH_PREFETCH_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc;
    logic [31:0] pc;
    logic        ready;
    bit          auto_pc;
    bit          rand_gnt;
    int          lat_min;
    int          lat_max;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] glog[$];
    logic        o_req, o_valid, o_pop;
    logic [31:0] o_addr, o_inst;

    always #5 clk = ~clk;

    inst_prefetch #(.DEPTH(DEPTH), .RESET_ADDR(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_addr_i (fetch_addr),
        .fetch_ready_i(fetch_ready),
        .fetch_valid_o(fetch_valid),
        .fetch_inst_o (fetch_inst),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
`ifdef IFETCH_PREFETCH_PERF_EN
        .hit_cnt_o    (hit_cnt),
        .miss_cnt_o   (miss_cnt),
`endif
        .mem_rdata_i  (mem_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // One clock: drive at negedge, sample 1 time unit later, update memory model, end at next negedge.
    task automatic cycle();
        fetch_addr  = pc;
        fetch_ready = ready;
        mem_gnt     = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(q_addr[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        #1;
        o_req   = mem_req;
        o_addr  = mem_addr;
        o_valid = fetch_valid;
        o_inst  = fetch_inst;
        o_pop   = fetch_valid && ready;
        if (mem_rvalid) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (mem_req && mem_gnt) begin
            q_addr.push_back(mem_addr);
            q_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
            glog.push_back(mem_addr);
        end
        @(posedge clk);
        cyc++;
        if (auto_pc && o_pop) pc = pc + 32'd4;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        pc         = 32'h0;
        ready      = 1'b0;
        fetch_addr = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        q_addr.delete();
        q_due.delete();
        glog.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; pc = 32'h0; ready = 1'b0; fetch_addr = 32'h0; fetch_ready = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b expected 0", fetch_valid); end
        n_checks++;
        if (fetch_inst !== NOP) begin n_fails++; $display("FAIL reset_inst: got %h expected %h", fetch_inst, NOP); end
        n_checks++;
        if (mem_req !== 1'b0) begin n_fails++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        n_checks++;
        if (mem_addr !== 32'h0) begin n_fails++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
`ifdef IFETCH_PREFETCH_PERF_EN
        n_checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            n_fails++; $display("FAIL reset_cnt: got %h/%h expected 0/0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_sequential();
        do_reset();
        auto_pc = 1'b1; ready = 1'b1; rand_gnt = 1'b0; lat_min = 1; lat_max = 1;
        for (int c = 0; c < 12; c++) begin
            cycle();
            n_checks++;
            if (o_req !== 1'b1 || o_addr !== 32'(4 * c)) begin
                n_fails++; $display("FAIL seq_req c%0d: got req=%b addr=%h expected req=1 addr=%h", c, o_req, o_addr, 32'(4 * c));
            end
            n_checks++;
            if (o_valid !== (c >= 2)) begin
                n_fails++; $display("FAIL seq_valid c%0d: got %b expected %b", c, o_valid, (c >= 2));
            end
            if (c >= 2) begin
                n_checks++;
                if (o_inst !== mem_word(32'(4 * (c - 2)))) begin
                    n_fails++; $display("FAIL seq_inst c%0d: got %h expected %h", c, o_inst, mem_word(32'(4 * (c - 2))));
                end
            end
        end
    endtask

    task automatic test_fill();
        logic [31:0] g0;
        do_reset();
        auto_pc = 1'b1; ready = 1'b0; rand_gnt = 1'b0; lat_min = 1; lat_max = 1;
        repeat (8) cycle();
        n_checks++;
        if (glog.size() != DEPTH) begin n_fails++; $display("FAIL fill_grants: got %0d expected %0d", glog.size(), DEPTH); end
        n_checks++;
        if (o_req !== 1'b0) begin n_fails++; $display("FAIL fill_req_idle: got %b expected 0", o_req); end
        ready = 1'b1;
        cycle();
        n_checks++;
        if (o_pop !== 1'b1 || o_inst !== mem_word(32'h0)) begin
            n_fails++; $display("FAIL fill_pop: got pop=%b inst=%h expected 1 %h", o_pop, o_inst, mem_word(32'h0));
        end
        ready = 1'b0;
        glog.delete();
        repeat (6) cycle();
        g0 = (glog.size() > 0) ? glog[0] : 32'hFFFF_FFFF;
        n_checks++;
        if (glog.size() != 1 || g0 !== 32'h10) begin
            n_fails++; $display("FAIL fill_refill: got %0d grants first=%h expected 1 grant 00000010", glog.size(), g0);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        auto_pc = 1'b0; ready = 1'b0; rand_gnt = 1'b0; lat_min = 5; lat_max = 5;
        repeat (3) cycle();
        pc = 32'h100;
        cycle();
        n_checks++;
        if (o_req !== 1'b0 || o_valid !== 1'b0) begin
            n_fails++; $display("FAIL redir_T: got req=%b valid=%b expected 0 0", o_req, o_valid);
        end
        cycle();
        n_checks++;
        if (o_req !== 1'b1 || o_addr !== 32'h100) begin
            n_fails++; $display("FAIL redir_T1: got req=%b addr=%h expected 1 00000100", o_req, o_addr);
        end
        for (int c = 5; c < 10; c++) begin
            cycle();
            n_checks++;
            if (o_valid !== 1'b0) begin n_fails++; $display("FAIL redir_drop c%0d: got valid=%b expected 0", c, o_valid); end
        end
        cycle();
        n_checks++;
        if (o_valid !== 1'b1 || o_inst !== mem_word(32'h100)) begin
            n_fails++; $display("FAIL redir_hit: got valid=%b inst=%h expected 1 %h", o_valid, o_inst, mem_word(32'h100));
        end
`ifdef IFETCH_PREFETCH_PERF_EN
        n_checks++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            n_fails++; $display("FAIL redir_cnt: got miss=%0d hit=%0d expected 1 0", miss_cnt, hit_cnt);
        end
`endif
    endtask

    task automatic test_random();
        int          pops = 0;
        int          guard = 0;
        logic [31:0] exp_pc;
        do_reset();
        auto_pc = 1'b1; rand_gnt = 1'b1; lat_min = 1; lat_max = 5;
        while (pops < 1000 && guard < 20000) begin
            ready  = ($urandom_range(0, 3) != 0);
            exp_pc = pc;
            cycle();
            guard++;
            if (o_pop) begin
                pops++;
                n_checks++;
                if (o_inst !== mem_word(exp_pc)) begin
                    n_fails++; $display("FAIL rand_data pc=%h: got %h expected %h", exp_pc, o_inst, mem_word(exp_pc));
                end
            end
            n_checks++;
            if (int'(dut.count_q) + int'(dut.outstanding_q) > int'(DEPTH)) begin
                n_fails++; $display("FAIL rand_inflight: got %0d expected <= %0d", int'(dut.count_q) + int'(dut.outstanding_q), DEPTH);
            end
        end
        n_checks++;
        if (pops < 1000) begin n_fails++; $display("FAIL rand_timeout: got %0d pops expected 1000", pops); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a;
        logic [31:0] got_a;
        do_reset();
        auto_pc = 1'b1; ready = 1'b1; rand_gnt = 1'b0; lat_min = 1; lat_max = 1;
        pc = 32'hFFFF_FFF8;
        for (int c = 0; c < 7; c++) begin
            cycle();
            if (c >= 3) begin
                exp_a = 32'hFFFF_FFF8 + 32'(4 * (c - 3));
                n_checks++;
                if (o_valid !== 1'b1 || o_inst !== mem_word(exp_a)) begin
                    n_fails++; $display("FAIL wrap_inst c%0d: got valid=%b inst=%h expected 1 %h", c, o_valid, o_inst, mem_word(exp_a));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp_a = 32'hFFFF_FFF8 + 32'(4 * i);
            got_a = (glog.size() > i) ? glog[i] : 32'h1;
            n_checks++;
            if (got_a !== exp_a) begin n_fails++; $display("FAIL wrap_addr %0d: got %h expected %h", i, got_a, exp_a); end
        end
`ifdef IFETCH_PREFETCH_PERF_EN
        n_checks++;
        if (miss_cnt !== 32'd1) begin n_fails++; $display("FAIL wrap_miss: got %0d expected 1", miss_cnt); end
`endif
    endtask

    task automatic test_reset_midop();
        do_reset();
        auto_pc = 1'b0; ready = 1'b0; rand_gnt = 1'b0; lat_min = 3; lat_max = 3;
        repeat (5) cycle();
        mem_rvalid = 1'b0;
        #1;
        n_checks++;
        if (fetch_valid !== 1'b1 || mem_req !== 1'b0) begin
            n_fails++; $display("FAIL midop_pre: got valid=%b req=%b expected 1 0", fetch_valid, mem_req);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (fetch_valid !== 1'b0 || fetch_inst !== NOP || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            n_fails++; $display("FAIL midop_async: got valid=%b inst=%h req=%b addr=%h expected 0 %h 0 0",
                                fetch_valid, fetch_inst, mem_req, mem_addr, NOP);
        end
        do_reset();
        auto_pc = 1'b1; ready = 1'b1; lat_min = 1; lat_max = 1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (c == 0) begin
                n_checks++;
                if (o_req !== 1'b1 || o_addr !== 32'h0) begin
                    n_fails++; $display("FAIL midop_restart: got req=%b addr=%h expected 1 0", o_req, o_addr);
                end
            end
        end
        n_checks++;
        if (o_valid !== 1'b1 || o_inst !== mem_word(32'h0)) begin
            n_fails++; $display("FAIL midop_first: got valid=%b inst=%h expected 1 %h", o_valid, o_inst, mem_word(32'h0));
        end
    endtask

    initial begin
        auto_pc = 1'b0; rand_gnt = 1'b0; lat_min = 1; lat_max = 1; cyc = 0;
        test_reset();
        test_sequential();
        test_fill();
        test_redirect();
        test_random();
        test_wrap();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
